// File: rtl/range_table.sv
// Range lookup table: a ring of DEPTH {valid, first, last} entries filled at a write cursor,
// with a free-by-start-address operation and a single-cycle registered lookup.
module range_table #(
    parameter int unsigned      DEPTH      = 8,
    parameter int unsigned      AW         = 32,
    parameter int unsigned      TAG_W      = 4,
    parameter logic [TAG_W-1:0] REGION_TAG = 4'h8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       wr_en_i,
    input  logic [AW-1:0]              wr_first_i,
    input  logic [AW-1:0]              wr_last_i,
    input  logic                       free_en_i,
    input  logic [AW-1:0]              free_addr_i,
    input  logic                       lk_valid_i,
    input  logic [AW-1:0]              lk_addr_i,
    output logic                       lk_valid_o,
    output logic                       lk_hit_o,
    output logic [$clog2(DEPTH)-1:0]   lk_idx_o,
    output logic [AW-1:0]              lk_first_o,
    output logic [AW-1:0]              lk_last_o,
    output logic [AW-1:0]              recent_first_o,
    output logic [AW-1:0]              recent_last_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       ovw_o,
    output logic                       wr_err_o,
    output logic                       free_hit_o
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid_q;
    logic [AW-1:0]    first_q [DEPTH];
    logic [AW-1:0]    last_q  [DEPTH];
    logic [IW-1:0]    cursor_q;

    logic             wr_ok;
    logic [DEPTH-1:0] free_match;
    logic [DEPTH-1:0] valid_n;
    logic [DEPTH-1:0] lk_match;
    logic             lk_hit_n;
    logic [IW-1:0]    lk_idx_n;
    logic [AW-1:0]    lk_first_n;
    logic [AW-1:0]    lk_last_n;
    logic [IW-1:0]    recent_idx;
    logic [CW-1:0]    count_n;

    assign wr_ok = wr_en_i && (wr_last_i >= wr_first_i);

    // Free clears on pre-edge contents; the write slot is then set, so a slot that
    // is both freed and written ends valid with the new data.
    always_comb begin
        free_match = '0;
        valid_n    = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            free_match[i] = free_en_i && valid_q[i] && (first_q[i] == free_addr_i);
            valid_n[i]    = valid_q[i] && !free_match[i];
            if (wr_ok && (IW'(i) == cursor_q)) begin
                valid_n[i] = 1'b1;
            end
        end
    end

    always_comb begin
        lk_match   = '0;
        lk_hit_n   = 1'b0;
        lk_idx_n   = '0;
        lk_first_n = '0;
        lk_last_n  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            lk_match[i] = valid_q[i] && (lk_addr_i[AW-1 -: TAG_W] == REGION_TAG) &&
                          (first_q[i] <= lk_addr_i) && (lk_addr_i <= last_q[i]);
            if (lk_match[i] && !lk_hit_n) begin
                lk_hit_n   = 1'b1;
                lk_idx_n   = IW'(i);
                lk_first_n = first_q[i];
                lk_last_n  = last_q[i];
            end
        end
    end

    always_comb begin
        count_n = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            count_n = count_n + CW'(valid_q[i]);
        end
    end

    assign count_o        = count_n;
    assign full_o         = (count_n == CW'(DEPTH));
    assign recent_idx     = cursor_q - IW'(1);
    assign recent_first_o = first_q[recent_idx];
    assign recent_last_o  = last_q[recent_idx];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q    <= '0;
            cursor_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                first_q[i] <= '0;
                last_q[i]  <= '0;
            end
            ovw_o      <= 1'b0;
            wr_err_o   <= 1'b0;
            free_hit_o <= 1'b0;
            lk_valid_o <= 1'b0;
            lk_hit_o   <= 1'b0;
            lk_idx_o   <= '0;
            lk_first_o <= '0;
            lk_last_o  <= '0;
        end else begin
            ovw_o      <= 1'b0;
            wr_err_o   <= 1'b0;
            free_hit_o <= 1'b0;
            if (flush_i) begin
                valid_q  <= '0;
                cursor_q <= '0;
            end else begin
                valid_q    <= valid_n;
                wr_err_o   <= wr_en_i && !wr_ok;
                free_hit_o <= |free_match;
                if (wr_ok) begin
                    first_q[cursor_q] <= wr_first_i;
                    last_q[cursor_q]  <= wr_last_i;
                    cursor_q          <= cursor_q + IW'(1);
                    ovw_o             <= valid_q[cursor_q];
                end
            end
            // Lookup sees pre-edge contents, including during a flush.
            lk_valid_o <= lk_valid_i;
            if (lk_valid_i) begin
                lk_hit_o   <= lk_hit_n;
                lk_idx_o   <= lk_idx_n;
                lk_first_o <= lk_first_n;
                lk_last_o  <= lk_last_n;
            end else begin
                lk_hit_o   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_range_table.sv
// Directed bench for range_table (DEPTH=8, AW=32): insert, lookup, wrap, reject, free, flush, reset.
module tb_range_table;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        wr_en_i;
    logic [31:0] wr_first_i;
    logic [31:0] wr_last_i;
    logic        free_en_i;
    logic [31:0] free_addr_i;
    logic        lk_valid_i;
    logic [31:0] lk_addr_i;
    logic        lk_valid_o;
    logic        lk_hit_o;
    logic [2:0]  lk_idx_o;
    logic [31:0] lk_first_o;
    logic [31:0] lk_last_o;
    logic [31:0] recent_first_o;
    logic [31:0] recent_last_o;
    logic [3:0]  count_o;
    logic        full_o;
    logic        ovw_o;
    logic        wr_err_o;
    logic        free_hit_o;

    int vectors    = 0;
    int miscompares = 0;

    range_table #(
        .DEPTH     (8),
        .AW        (32),
        .TAG_W     (4),
        .REGION_TAG(4'h8)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .flush_i       (flush_i),
        .wr_en_i       (wr_en_i),
        .wr_first_i    (wr_first_i),
        .wr_last_i     (wr_last_i),
        .free_en_i     (free_en_i),
        .free_addr_i   (free_addr_i),
        .lk_valid_i    (lk_valid_i),
        .lk_addr_i     (lk_addr_i),
        .lk_valid_o    (lk_valid_o),
        .lk_hit_o      (lk_hit_o),
        .lk_idx_o      (lk_idx_o),
        .lk_first_o    (lk_first_o),
        .lk_last_o     (lk_last_o),
        .recent_first_o(recent_first_o),
        .recent_last_o (recent_last_o),
        .count_o       (count_o),
        .full_o        (full_o),
        .ovw_o         (ovw_o),
        .wr_err_o      (wr_err_o),
        .free_hit_o    (free_hit_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        flush_i     = 1'b0;
        wr_en_i     = 1'b0;
        wr_first_i  = '0;
        wr_last_i   = '0;
        free_en_i   = 1'b0;
        free_addr_i = '0;
        lk_valid_i  = 1'b0;
        lk_addr_i   = '0;
    endtask

    // One clock edge, then settle and return inputs to idle.
    task automatic step();
        @(posedge clk_i);
        #1;
        idle();
    endtask

    task automatic wr(input logic [31:0] f, input logic [31:0] l);
        wr_en_i    = 1'b1;
        wr_first_i = f;
        wr_last_i  = l;
    endtask

    task automatic lk(input logic [31:0] a);
        lk_valid_i = 1'b1;
        lk_addr_i  = a;
    endtask

    task automatic fr(input logic [31:0] a);
        free_en_i   = 1'b1;
        free_addr_i = a;
    endtask

    initial begin
        idle();
        rst_i = 1'b1;
        // Activity during reset must be ignored.
        wr(32'h8000_1000, 32'h8000_10FF);
        lk(32'h8000_1000);
        @(posedge clk_i); #1;
        wr(32'h8000_1000, 32'h8000_10FF);
        lk(32'h8000_1000);
        @(posedge clk_i); #1;
        check("rst_lk_valid", 32'(lk_valid_o), 32'd0);
        check("rst_count",    32'(count_o),    32'd0);
        check("rst_full",     32'(full_o),     32'd0);
        check("rst_recent",   recent_first_o,  32'h0);
        check("rst_ovw",      32'(ovw_o),      32'd0);
        rst_i = 1'b0;

        // First write in the first non-reset cycle.
        wr(32'h8000_1000, 32'h8000_10FF); step();
        check("w1_count",   32'(count_o),   32'd1);
        check("w1_rfirst",  recent_first_o, 32'h8000_1000);
        check("w1_rlast",   recent_last_o,  32'h8000_10FF);
        check("w1_ovw",     32'(ovw_o),     32'd0);
        check("w1_err",     32'(wr_err_o),  32'd0);

        lk(32'h8000_10FF); step();
        check("lk_last_valid", 32'(lk_valid_o), 32'd1);
        check("lk_last_hit",   32'(lk_hit_o),   32'd1);
        check("lk_last_idx",   32'(lk_idx_o),   32'd0);
        check("lk_last_first", lk_first_o,      32'h8000_1000);
        check("lk_last_last",  lk_last_o,       32'h8000_10FF);

        lk(32'h8000_1100); step();
        check("lk_over_valid", 32'(lk_valid_o), 32'd1);
        check("lk_over_hit",   32'(lk_hit_o),   32'd0);
        check("lk_over_first", lk_first_o,      32'h0);
        lk(32'h9000_1000); step();
        check("lk_tag_hit",    32'(lk_hit_o),   32'd0);
        check("lk_tag_idx",    32'(lk_idx_o),   32'd0);

        lk(32'h8000_1000); step();
        check("lk_first_hit",  32'(lk_hit_o),   32'd1);
        step();
        check("lk_idle_valid", 32'(lk_valid_o), 32'd0);
        check("lk_idle_hit",   32'(lk_hit_o),   32'd0);
        check("lk_idle_hold",  lk_first_o,      32'h8000_1000);

        // Rejected write: inverted range.
        wr(32'h8000_0200, 32'h8000_0100); step();
        check("err_pulse",  32'(wr_err_o),  32'd1);
        check("err_count",  32'(count_o),   32'd1);
        check("err_recent", recent_first_o, 32'h8000_1000);
        step();
        check("err_clear",  32'(wr_err_o),  32'd0);

        // Fill slots 1..7.
        for (int k = 1; k < 8; k++) begin
            wr(32'h8001_0000 + 32'(k) * 32'h100, 32'h8001_000F + 32'(k) * 32'h100);
            step();
            check("fill_ovw", 32'(ovw_o), 32'd0);
        end
        check("fill_count", 32'(count_o), 32'd8);
        check("fill_full",  32'(full_o),  32'd1);

        // 9th write overwrites slot 0.
        wr(32'h8005_0000, 32'h8005_00FF); step();
        check("w9_ovw",    32'(ovw_o),     32'd1);
        check("w9_count",  32'(count_o),   32'd8);
        check("w9_full",   32'(full_o),    32'd1);
        check("w9_recent", recent_first_o, 32'h8005_0000);
        step();
        check("ovw_clear", 32'(ovw_o),     32'd0);
        lk(32'h8005_0010); step();
        check("w9_lk_hit", 32'(lk_hit_o),  32'd1);
        check("w9_lk_idx", 32'(lk_idx_o),  32'd0);

        // Cursor wrapped to 1; same-cycle lookup must not see the write.
        wr(32'h8006_0000, 32'h8006_000F); lk(32'h8006_0005); step();
        check("w10_ovw",   32'(ovw_o),     32'd1);
        check("w10_lk_hit",32'(lk_hit_o),  32'd0);
        lk(32'h8006_0005); step();
        check("w10_hit",   32'(lk_hit_o),  32'd1);
        check("w10_idx",   32'(lk_idx_o),  32'd1);
        lk(32'h8001_0105); step();
        check("old1_hit",  32'(lk_hit_o),  32'd0);

        // Flush with concurrent write and lookup.
        flush_i = 1'b1; wr(32'h8007_0000, 32'h8007_00FF); lk(32'h8005_0010); step();
        check("fl_count",  32'(count_o),   32'd0);
        check("fl_lk_hit", 32'(lk_hit_o),  32'd1);
        check("fl_lk_idx", 32'(lk_idx_o),  32'd0);
        check("fl_ovw",    32'(ovw_o),     32'd0);
        check("fl_recent", recent_first_o, 32'h8001_0700);
        lk(32'h8005_0010); step();
        check("fl_after_hit", 32'(lk_hit_o), 32'd0);

        // Two entries sharing a start address, then free + write together.
        wr(32'h8000_2000, 32'h8000_20FF); step();
        check("fa_recent", recent_first_o, 32'h8000_2000);
        wr(32'h8000_2000, 32'h8000_200F); step();
        wr(32'h8000_3000, 32'h8000_3FFF); step();
        check("fa_count",  32'(count_o),   32'd3);
        lk(32'h8000_2005); step();
        check("multi_idx",  32'(lk_idx_o), 32'd0);
        check("multi_last", lk_last_o,     32'h8000_20FF);
        fr(32'h8000_0000); step();
        check("free_none",  32'(free_hit_o), 32'd0);
        fr(32'h8000_2000); wr(32'h8000_4000, 32'h8000_40FF); step();
        check("free_hit",   32'(free_hit_o), 32'd1);
        check("free_count", 32'(count_o),    32'd2);
        check("free_ovw",   32'(ovw_o),      32'd0);
        lk(32'h8000_2005); step();
        check("free_gone",  32'(lk_hit_o),   32'd0);
        check("free_pulse", 32'(free_hit_o), 32'd0);
        lk(32'h8000_4010); step();
        check("free_new_idx", 32'(lk_idx_o), 32'd3);

        // Bring the cursor round to slot 2 (holding 0x8000_3000) for a free/write clash.
        for (int k = 4; k < 8; k++) begin
            wr(32'h8000_8000, 32'h8000_80FF); step();
        end
        wr(32'h8000_9000, 32'h8000_90FF); step();
        wr(32'h8000_8000, 32'h8000_80FF); step();
        check("clash_pre_count", 32'(count_o), 32'd8);
        fr(32'h8000_3000); wr(32'h8000_A000, 32'h8000_A0FF); step();
        check("clash_free_hit",  32'(free_hit_o), 32'd1);
        check("clash_count",     32'(count_o),    32'd8);
        lk(32'h8000_A010); step();
        check("clash_new_idx",   32'(lk_idx_o),   32'd2);
        check("clash_new_hit",   32'(lk_hit_o),   32'd1);
        lk(32'h8000_3005); step();
        check("clash_old_hit",   32'(lk_hit_o),   32'd0);
        fr(32'h8000_8000); step();
        check("multi_free_hit",   32'(free_hit_o), 32'd1);
        check("multi_free_count", 32'(count_o),    32'd3);
        check("multi_free_full",  32'(full_o),     32'd0);

        // Reset beats a concurrent lookup.
        rst_i = 1'b1; lk(32'h8000_9000);
        @(posedge clk_i); #1;
        check("rst2_lk_valid", 32'(lk_valid_o), 32'd0);
        check("rst2_count",    32'(count_o),    32'd0);
        check("rst2_recent",   recent_first_o,  32'h0);
        rst_i = 1'b0; idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
